// File: rtl/decode_queue_if.sv
// Handshake bundle between IF, the decode queue and EX.
// The slave modport is the queue's view; master is the surrounding pipeline.
interface decode_queue_if #(
  parameter int DEPTH  = 4,
  parameter int CTRL_W = 64
);
  logic                         in_valid;
  logic                         in_ready;
  logic [31:0]                  in_pc;
  logic [31:0]                  in_instr;
  logic                         flush;
  logic                         hz_valid;
  logic [4:0]                   hz_rd;
  logic                         out_valid;
  logic                         out_ready;
  logic [CTRL_W-1:0]            out_ctrl;
  logic [4:0]                   out_rd;
  logic                         out_illegal;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, hz_valid, hz_rd, out_ready,
    output in_ready, out_valid, out_ctrl, out_rd, out_illegal, count
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, hz_valid, hz_rd, out_ready,
    input  in_ready, out_valid, out_ctrl, out_rd, out_illegal, count
  );
endinterface

// File: rtl/decode_queue.sv
// ID-stage decoder feeding a DEPTH-entry circular FIFO of decoded control words,
// with valid/ready on both sides, flush, and a load-use hold on the head entry.
module decode_queue #(
  parameter int DEPTH    = 4,
  parameter int M_EXT_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  decode_queue_if.slave q
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef struct packed {
    logic alu_src_a_pc;
    logic alu_src_b_imm;
    logic is_branch;
    logic is_jump;
    logic m_extension_act;
    logic alt_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic load_regfile;
    logic wb_sel_mem;
    logic wb_sel_pc4;
  } wb_ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    ex_ctrl_t    ex;
    mem_ctrl_t   mem;
    wb_ctrl_t    wb;
  } ctrl_word_t;

  typedef struct packed {
    ctrl_word_t ctrl;
    logic [4:0] rd;
    logic       illegal;
  } entry_t;

  function automatic entry_t decode(input logic [31:0] pc, input logic [31:0] instr);
    entry_t     e;
    logic       ill;
    logic [4:0] rd, rs1, rs2;
    e    = '0;
    ill  = 1'b0;
    rd   = instr[11:7];
    rs1  = instr[19:15];
    rs2  = instr[24:20];
    e.ctrl.pc     = pc;
    e.ctrl.opcode = instr[6:0];
    e.ctrl.funct3 = instr[14:12];
    case (instr[6:0])
      OP_LUI: begin
        e.rd = rd;
        e.ctrl.ex.alu_src_b_imm  = 1'b1;
        e.ctrl.wb.load_regfile   = 1'b1;
      end
      OP_AUIPC: begin
        e.rd = rd;
        e.ctrl.ex.alu_src_a_pc   = 1'b1;
        e.ctrl.ex.alu_src_b_imm  = 1'b1;
        e.ctrl.wb.load_regfile   = 1'b1;
      end
      OP_JAL: begin
        e.rd = rd;
        e.ctrl.ex.alu_src_a_pc   = 1'b1;
        e.ctrl.ex.alu_src_b_imm  = 1'b1;
        e.ctrl.ex.is_jump        = 1'b1;
        e.ctrl.wb.load_regfile   = 1'b1;
        e.ctrl.wb.wb_sel_pc4     = 1'b1;
      end
      OP_JALR: begin
        e.rd = rd;
        e.ctrl.rs1 = rs1;
        e.ctrl.ex.alu_src_b_imm  = 1'b1;
        e.ctrl.ex.is_jump        = 1'b1;
        e.ctrl.wb.load_regfile   = 1'b1;
        e.ctrl.wb.wb_sel_pc4     = 1'b1;
      end
      OP_BR: begin
        e.ctrl.rs1 = rs1;
        e.ctrl.rs2 = rs2;
        e.ctrl.ex.is_branch      = 1'b1;
      end
      OP_STORE: begin
        e.ctrl.rs1 = rs1;
        e.ctrl.rs2 = rs2;
        e.ctrl.ex.alu_src_b_imm  = 1'b1;
        e.ctrl.mem.mem_write     = 1'b1;
      end
      OP_LOAD: begin
        e.rd = rd;
        e.ctrl.rs1 = rs1;
        e.ctrl.ex.alu_src_b_imm  = 1'b1;
        e.ctrl.mem.mem_read      = 1'b1;
        e.ctrl.wb.load_regfile   = 1'b1;
        e.ctrl.wb.wb_sel_mem     = 1'b1;
      end
      OP_IMM: begin
        e.rd = rd;
        e.ctrl.rs1 = rs1;
        e.ctrl.ex.alu_src_b_imm  = 1'b1;
        e.ctrl.ex.alt_op         = (instr[14:12] == 3'b101) && instr[30];
        e.ctrl.wb.load_regfile   = 1'b1;
      end
      OP_REG: begin
        if (instr[25] && (M_EXT_EN == 0)) begin
          ill = 1'b1;
        end else begin
          e.rd = rd;
          e.ctrl.rs1 = rs1;
          e.ctrl.rs2 = rs2;
          e.ctrl.ex.alt_op          = instr[30];
          e.ctrl.ex.m_extension_act = instr[25];
          e.ctrl.wb.load_regfile    = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    // Illegal entries keep pc/opcode/funct3 for the trap unit but carry no operands.
    if (ill) begin
      e.rd       = '0;
      e.ctrl.rs1 = '0;
      e.ctrl.rs2 = '0;
      e.ctrl.ex  = '0;
      e.ctrl.mem = '0;
      e.ctrl.wb  = '0;
      e.illegal  = 1'b1;
    end else begin
      e.ctrl.valid = 1'b1;
    end
    return e;
  endfunction

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  entry_t head;
  logic   empty, hold, enq, deq;

  assign head  = mem_q[rptr_q];
  assign empty = (count_q == '0);
  assign hold  = q.hz_valid && (q.hz_rd != 5'd0) &&
                 ((head.ctrl.rs1 == q.hz_rd) || (head.ctrl.rs2 == q.hz_rd));

  assign q.in_ready    = (count_q != CNT_W'(DEPTH));
  assign q.out_valid   = !empty && !hold;
  assign q.out_ctrl    = empty ? '0 : head.ctrl;
  assign q.out_rd      = empty ? '0 : head.rd;
  assign q.out_illegal = empty ? 1'b0 : head.illegal;
  assign q.count       = count_q;

  assign enq = q.in_valid && q.in_ready && !q.flush;
  assign deq = q.out_valid && q.out_ready && !q.flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (q.flush) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (enq) wptr_d = wptr_q + PTR_W'(1);
      if (deq) rptr_d = rptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; only the pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (rst && enq) mem_q[wptr_q] <= decode(q.in_pc, q.in_instr);
  end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: two builds (M extension on/off) share one stimulus.
module tb_decode_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, hz_valid, out_ready;
  logic [31:0] in_pc, in_instr;
  logic [4:0]  hz_rd;

  int checks = 0;
  int errors = 0;

  decode_queue_if #(.DEPTH(DEPTH), .CTRL_W(64)) qa ();
  decode_queue_if #(.DEPTH(DEPTH), .CTRL_W(64)) qb ();

  assign qa.in_valid = in_valid;  assign qb.in_valid = in_valid;
  assign qa.in_pc    = in_pc;     assign qb.in_pc    = in_pc;
  assign qa.in_instr = in_instr;  assign qb.in_instr = in_instr;
  assign qa.flush    = flush;     assign qb.flush    = flush;
  assign qa.hz_valid = hz_valid;  assign qb.hz_valid = hz_valid;
  assign qa.hz_rd    = hz_rd;     assign qb.hz_rd    = hz_rd;
  assign qa.out_ready = out_ready; assign qb.out_ready = out_ready;

  decode_queue #(.DEPTH(DEPTH), .M_EXT_EN(1)) dut_m  (.clk(clk), .rst(rst), .q(qa.slave));
  decode_queue #(.DEPTH(DEPTH), .M_EXT_EN(0)) dut_nm (.clk(clk), .rst(rst), .q(qb.slave));

  always #5 clk = ~clk;

  // Control word layout: valid | pc | opcode | funct3 | rs1 | rs2 | ex[6] | mem[2] | wb[3]
  function automatic logic [63:0] cw(input logic v, input logic [31:0] pc, input logic [6:0] op,
                                     input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [5:0] ex, input logic [1:0] mem, input logic [2:0] wb);
    return {v, pc, op, f3, rs1, rs2, ex, mem, wb};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, rd, 7'h13};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic deq(input string tag, input logic [4:0] rd, input logic [31:0] pc);
    chk({tag, ".vld"}, 64'(qa.out_valid), 64'd1);
    chk({tag, ".rd"},  64'(qa.out_rd), 64'(rd));
    chk({tag, ".pc"},  64'(qa.out_ctrl[62:31]), 64'(pc));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".cnt"},  64'(qa.count), 64'd0);
    chk({tag, ".vld"},  64'(qa.out_valid), 64'd0);
    chk({tag, ".ctrl"}, qa.out_ctrl, 64'd0);
    chk({tag, ".rd"},   64'(qa.out_rd), 64'd0);
    chk({tag, ".ill"},  64'(qa.out_illegal), 64'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; hz_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0; hz_rd = '0;
    tick(); tick();
    rst = 1'b1;
    chk_empty("reset");
    chk("reset.rdy", 64'(qa.in_ready), 64'd1);

    // Basic decode of addi x1,x0,5 with one-cycle latency and no bypass
    in_valid = 1'b1; in_pc = 32'h60; in_instr = 32'h0050_0093;
    #1;
    chk("basic.nobypass", 64'(qa.out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("basic.vld", 64'(qa.out_valid), 64'd1);
    chk("basic.cnt", 64'(qa.count), 64'd1);
    chk("basic.rd",  64'(qa.out_rd), 64'd1);
    chk("basic.ctrl", qa.out_ctrl, cw(1'b1, 32'h60, 7'h13, 3'd0, 5'd0, 5'd0, 6'b010000, 2'b00, 3'b100));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_empty("basic.drain");

    // More opcodes: lw x5,8(x6); beq x1,x2,8; jal x1,8
    enq(32'h70, 32'h0083_2283);
    enq(32'h74, 32'h0020_8463);
    enq(32'h78, 32'h0080_00EF);
    chk("dec.lw", qa.out_ctrl, cw(1'b1, 32'h70, 7'h03, 3'd2, 5'd6, 5'd0, 6'b010000, 2'b10, 3'b110));
    deq("dec.lw", 5'd5, 32'h70);
    chk("dec.beq", qa.out_ctrl, cw(1'b1, 32'h74, 7'h63, 3'd0, 5'd1, 5'd2, 6'b001000, 2'b00, 3'b000));
    deq("dec.beq", 5'd0, 32'h74);
    chk("dec.jal", qa.out_ctrl, cw(1'b1, 32'h78, 7'h6F, 3'd0, 5'd0, 5'd0, 6'b110100, 2'b00, 3'b101));
    deq("dec.jal", 5'd1, 32'h78);

    // Fill, hold the fifth, then wrap the pointers
    for (int k = 1; k <= 4; k++) enq(32'h100 + 32'(4*k), addi(5'(k), 12'(k)));
    chk("full.cnt", 64'(qa.count), 64'd4);
    chk("full.rdy", 64'(qa.in_ready), 64'd0);
    enq(32'h114, addi(5'd5, 12'd5));
    chk("full.held", 64'(qa.count), 64'd4);
    deq("wrap.d1", 5'd1, 32'h104);
    deq("wrap.d2", 5'd2, 32'h108);
    enq(32'h114, addi(5'd5, 12'd5));
    in_valid = 1'b1; in_pc = 32'h118; in_instr = addi(5'd6, 12'd6); out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap.both.cnt", 64'(qa.count), 64'd3);
    enq(32'h11C, addi(5'd7, 12'd7));
    chk("wrap.cnt", 64'(qa.count), 64'd4);
    in_valid = 1'b1; in_pc = 32'h120; in_instr = addi(5'd8, 12'd8); out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fullnopass.cnt", 64'(qa.count), 64'd3);
    deq("wrap.d5", 5'd5, 32'h114);
    deq("wrap.d6", 5'd6, 32'h118);
    deq("wrap.d7", 5'd7, 32'h11C);
    chk_empty("wrap.end");

    // Load-use hold on add x3,x2,x1
    enq(32'h200, 32'h0011_01B3);
    hz_valid = 1'b1; hz_rd = 5'd2; out_ready = 1'b1;
    #1;
    chk("hz.hold0", 64'(qa.out_valid), 64'd0);
    in_valid = 1'b1; in_pc = 32'h204; in_instr = addi(5'd9, 12'd9);
    tick();
    in_valid = 1'b0;
    chk("hz.hold1.vld", 64'(qa.out_valid), 64'd0);
    chk("hz.hold1.cnt", 64'(qa.count), 64'd2);
    tick();
    chk("hz.hold2.vld", 64'(qa.out_valid), 64'd0);
    chk("hz.hold2.cnt", 64'(qa.count), 64'd2);
    hz_valid = 1'b0;
    #1;
    chk("hz.rel.vld", 64'(qa.out_valid), 64'd1);
    chk("hz.rel.rd",  64'(qa.out_rd), 64'd3);
    tick();
    out_ready = 1'b0;
    chk("hz.issued.cnt", 64'(qa.count), 64'd1);
    hz_valid = 1'b1; hz_rd = 5'd0;
    #1;
    chk("hz.rd0.vld", 64'(qa.out_valid), 64'd1);
    deq("hz.addi9", 5'd9, 32'h204);
    enq(32'h208, 32'h0011_01B3);
    hz_rd = 5'd1;
    #1;
    chk("hz.rs2.vld", 64'(qa.out_valid), 64'd0);
    hz_rd = 5'd0;
    #1;
    deq("hz.rd0.add", 5'd3, 32'h208);
    hz_valid = 1'b0;

    // M extension in both builds, then an illegal word that must never be held
    enq(32'h300, 32'h0220_81B3);
    chk("mul.m.ctrl", qa.out_ctrl, cw(1'b1, 32'h300, 7'h33, 3'd0, 5'd1, 5'd2, 6'b000010, 2'b00, 3'b100));
    chk("mul.m.ill",  64'(qa.out_illegal), 64'd0);
    chk("mul.m.rd",   64'(qa.out_rd), 64'd3);
    chk("mul.nm.ctrl", qb.out_ctrl, cw(1'b0, 32'h300, 7'h33, 3'd0, 5'd0, 5'd0, 6'b000000, 2'b00, 3'b000));
    chk("mul.nm.ill",  64'(qb.out_illegal), 64'd1);
    chk("mul.nm.rd",   64'(qb.out_rd), 64'd0);
    chk("mul.nm.vld",  64'(qb.out_valid), 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    enq(32'h304, 32'hFFFF_FFFF);
    hz_valid = 1'b1; hz_rd = 5'd31;
    #1;
    chk("ill.m.ill",  64'(qa.out_illegal), 64'd1);
    chk("ill.nm.ill", 64'(qb.out_illegal), 64'd1);
    chk("ill.m.ctrl", qa.out_ctrl, cw(1'b0, 32'h304, 7'h7F, 3'd7, 5'd0, 5'd0, 6'b000000, 2'b00, 3'b000));
    chk("ill.nohold", 64'(qa.out_valid), 64'd1);
    hz_valid = 1'b0;
    deq("ill.deq", 5'd0, 32'h304);
    chk("ill.nm.cnt", 64'(qb.count), 64'd0);

    // Flush with enqueue and dequeue requested in the same cycle
    for (int k = 0; k < 3; k++) enq(32'h400 + 32'(4*k), addi(5'(20+k), 12'(k)));
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h40C; in_instr = addi(5'd10, 12'd10); out_ready = 1'b1;
    #1;
    chk("flush.rdy", 64'(qa.in_ready), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_empty("flush");
    enq(32'h410, addi(5'd11, 12'd11));
    chk("flush.next.cnt", 64'(qa.count), 64'd1);
    deq("flush.next", 5'd11, 32'h410);
    for (int k = 0; k < 4; k++) enq(32'h420 + 32'(4*k), addi(5'(24+k), 12'(k)));
    flush = 1'b1; in_valid = 1'b1;
    #1;
    chk("flushfull.rdy", 64'(qa.in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flushfull.cnt", 64'(qa.count), 64'd0);

    // Reset mid-stream
    for (int k = 0; k < 3; k++) enq(32'h500 + 32'(4*k), addi(5'(12+k), 12'(k)));
    chk("rstmid.pre", 64'(qa.count), 64'd3);
    rst = 1'b0; in_valid = 1'b1; in_pc = 32'h50C; in_instr = addi(5'd16, 12'd1); out_ready = 1'b1;
    tick();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    chk_empty("rstmid");
    in_valid = 1'b1; in_pc = 32'h600; in_instr = addi(5'd17, 12'd17);
    #1;
    chk("rstmid.lat0", 64'(qa.out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("rstmid.cnt", 64'(qa.count), 64'd1);
    deq("rstmid.first", 5'd17, 32'h600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
